// File: rtl/beat_pkg.sv
// beat_pkg: shared types and elaboration helpers for the synthetic heartbeat source.
//   beat_state_e  - beat FSM states (IDLE, HIGH, LOW)
//   CNT_W_DEF     - default period counter / divider width
//   dividend_of() - cycles per minute (CLK_HZ*60), the numerator of the period divide
//   cfg_ok()      - parameter sanity check evaluated at elaboration by the top level
package beat_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } beat_state_e;

  function automatic longint unsigned dividend_of(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

  // Dividend must fit the counter width, and the pulse must be shorter than
  // the fastest accepted period so LOW is never empty.
  function automatic bit cfg_ok(input longint unsigned clk_hz,
                                input int              cnt_w,
                                input longint unsigned pulse_cyc,
                                input longint unsigned max_bpm);
    longint unsigned dvd;
    dvd = dividend_of(clk_hz);
    if (cnt_w < 2 || cnt_w > 63) return 1'b0;
    if (dvd >= (64'd1 << cnt_w)) return 1'b0;
    if (max_bpm == 64'd0) return 1'b0;
    return pulse_cyc < (dvd / max_bpm);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per cycle.
//   clk, rst_n  - clock, async active-low reset
//   start       - accepted when not busy; captures dividend/divisor
//   dividend    - W-bit numerator
//   divisor     - W-bit denominator (caller guarantees non-zero)
//   busy        - high for the W iteration cycles
//   done        - one-cycle pulse when quotient is valid (busy already low)
//   quotient    - floor(dividend/divisor); remainder is discarded
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int SW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [SW-1:0] steps;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  // quo doubles as the dividend shift register: its MSB feeds the remainder
  // while quotient bits enter at the LSB.
  assign shifted  = {rem, quo[W-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign quotient = quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem   <= '0;
        quo   <= dividend;
        dvs   <= divisor;
        steps <= SW'(W);
        busy  <= 1'b1;
      end else if (busy) begin
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= shifted[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        steps <= steps - SW'(1);
        if (steps == SW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/beat_pulse_gen.sv
// beat_pulse_gen: synthetic heartbeat source driving a detector's button input.
//   clk, rst_n   - clock, async active-low reset
//   en           - run enable; dropping it lets the current period finish
//   bpm_in/valid - requested rate; bpm_ready is high while the divider is idle
//   beat         - active-high pulse, PULSE_CYC cycles, rising every period
//   beat_strobe  - one cycle at each beat rising edge
//   beat_count   - beats emitted since reset (wraps)
//   rate_err     - one-cycle pulse when an out-of-range rate was dropped
//   active       - a period is loaded and en is high
//
// state   | meaning
// IDLE    | no beat; waits for en and a loaded period, applies pending at once
// HIGH    | beat=1, cnt runs 0..PULSE_CYC-1
// LOW     | beat=0, cnt runs on to period-1; boundary applies pending
module beat_pulse_gen
  import beat_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BPM_W     = 8,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PULSE_CYC = 2_500_000,
  parameter int MIN_BPM   = 20,
  parameter int MAX_BPM   = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [BPM_W-1:0] bpm_in,
  input  logic             bpm_valid,
  output logic             bpm_ready,
  output logic             beat,
  output logic             beat_strobe,
  output logic [15:0]      beat_count,
  output logic             rate_err,
  output logic             active
);

  localparam logic [CNT_W-1:0] DIVIDEND   = CNT_W'(dividend_of(64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [BPM_W-1:0] BPM_LO     = BPM_W'(MIN_BPM);
  localparam logic [BPM_W-1:0] BPM_HI     = BPM_W'(MAX_BPM);

  if (!cfg_ok(64'(CLK_HZ), CNT_W, 64'(PULSE_CYC), 64'(MAX_BPM))) begin : g_cfg_err
    $error("beat_pulse_gen: CLK_HZ*60 exceeds CNT_W or PULSE_CYC too long for MAX_BPM");
  end

  logic             div_busy;
  logic             div_done;
  logic [CNT_W-1:0] div_q;
  logic             load_fire;
  logic             rate_bad;

  beat_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] pend;
  logic             loaded_vld;
  logic             pend_vld;

  assign bpm_ready = !div_busy;
  assign load_fire = bpm_valid && bpm_ready;
  assign rate_bad  = (bpm_in < BPM_LO) || (bpm_in > BPM_HI);

  seq_divider #(.W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (load_fire && !rate_bad),
    .dividend (DIVIDEND),
    .divisor  (CNT_W'(bpm_in)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      period      <= '0;
      pend        <= '0;
      loaded_vld  <= 1'b0;
      pend_vld    <= 1'b0;
      beat        <= 1'b0;
      beat_strobe <= 1'b0;
      beat_count  <= '0;
      rate_err    <= 1'b0;
      active      <= 1'b0;
    end else begin
      beat_strobe <= 1'b0;
      rate_err    <= load_fire && rate_bad;
      active      <= loaded_vld && en;

      // Fresh divide result parks in pending; the IDLE and boundary branches
      // below take it directly instead when they apply in the same cycle.
      if (div_done) begin
        pend     <= div_q;
        pend_vld <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (div_done) begin
            period     <= div_q;
            loaded_vld <= 1'b1;
            pend_vld   <= 1'b0;
          end else if (pend_vld) begin
            period     <= pend;
            loaded_vld <= 1'b1;
            pend_vld   <= 1'b0;
          end
          if (en && loaded_vld) begin
            state       <= ST_HIGH;
            cnt         <= '0;
            beat        <= 1'b1;
            beat_strobe <= 1'b1;
            beat_count  <= beat_count + 16'd1;
          end
        end
        ST_HIGH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == PULSE_LAST) begin
            state <= ST_LOW;
            beat  <= 1'b0;
          end
        end
        ST_LOW: begin
          if (cnt == period - CNT_W'(1)) begin
            cnt <= '0;
            if (en) begin
              if (div_done) begin
                period   <= div_q;
                pend_vld <= 1'b0;
              end else if (pend_vld) begin
                period   <= pend;
                pend_vld <= 1'b0;
              end
              state       <= ST_HIGH;
              beat        <= 1'b1;
              beat_strobe <= 1'b1;
              beat_count  <= beat_count + 16'd1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_pulse_gen.sv
// tb_beat_pulse_gen: directed stimulus with a scoreboard of expected beat rises
// (cycle, count, high width) and expected rate_err cycles, checked by a
// separate monitor process on the falling clock edge.
module tb_beat_pulse_gen;

  localparam int CLK_HZ = 1000;
  localparam int PULSE  = 50;
  localparam int CW     = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  bpm_in = '0;
  logic        bpm_valid = 1'b0;
  logic        bpm_ready;
  logic        beat;
  logic        beat_strobe;
  logic [15:0] beat_count;
  logic        rate_err;
  logic        active;

  beat_pulse_gen #(
    .CLK_HZ    (CLK_HZ),
    .BPM_W     (8),
    .CNT_W     (CW),
    .PULSE_CYC (PULSE),
    .MIN_BPM   (20),
    .MAX_BPM   (240)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .bpm_in      (bpm_in),
    .bpm_valid   (bpm_valid),
    .bpm_ready   (bpm_ready),
    .beat        (beat),
    .beat_strobe (beat_strobe),
    .beat_count  (beat_count),
    .rate_err    (rate_err),
    .active      (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int rise;
    int count;
    int width;
  } beat_exp_t;

  beat_exp_t beat_q[$];
  int        err_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int rise, input int count);
    beat_exp_t e;
    e.rise  = rise;
    e.count = count;
    e.width = PULSE;
    beat_q.push_back(e);
  endtask

  // Called at a falling edge; hs is the rising-edge cycle of the transfer.
  task automatic offer(input int bpm, input bit expect_err, output int hs);
    int guard;
    guard = 0;
    bpm_in    = 8'(bpm);
    bpm_valid = 1'b1;
    while (!bpm_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!bpm_ready) begin
      check("bpm_ready timeout", 0, 1);
      hs = -1;
    end else begin
      hs = cyc + 1;
      if (expect_err) err_q.push_back(hs);
    end
    @(negedge clk);
    bpm_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reset asserted between clock edges so an asynchronous drop is observable.
  task automatic do_reset();
    check("expected beats outstanding", beat_q.size(), 0);
    check("expected rate_err outstanding", err_q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst beat", beat, 0);
    check("rst beat_count", beat_count, 0);
    check("rst bpm_ready", bpm_ready, 1);
    check("rst active", active, 0);
    check("rst beat_strobe", beat_strobe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    bit        in_pulse;
    int        width;
    int        exp_w;
    beat_exp_t e;
    in_pulse = 1'b0;
    width    = 0;
    exp_w    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 1'b0;
      end else begin
        if (rate_err) begin
          if (err_q.size() == 0) check("unexpected rate_err", cyc, -1);
          else check("rate_err cycle", cyc, err_q.pop_front());
        end
        if (beat_strobe) begin
          if (beat_q.size() == 0) begin
            check("unexpected beat", cyc, -1);
            in_pulse = 1'b0;
          end else begin
            e = beat_q.pop_front();
            check("beat rise cycle", cyc, e.rise);
            check("beat_count at rise", beat_count, e.count);
            check("beat high at strobe", beat, 1);
            in_pulse = 1'b1;
            width    = 1;
            exp_w    = e.width;
          end
        end else if (in_pulse) begin
          if (beat) width++;
          else begin
            check("beat high width", width, exp_w);
            in_pulse = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int hs;
    int r0;
    int n;

    repeat (3) @(negedge clk);
    check("reset beat", beat, 0);
    check("reset beat_strobe", beat_strobe, 0);
    check("reset beat_count", beat_count, 0);
    check("reset rate_err", rate_err, 0);
    check("reset active", active, 0);
    check("reset bpm_ready", bpm_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Out-of-range rates are dropped without touching the divider.
    en = 1'b1;
    offer(19, 1'b1, hs);
    check("ready after bpm 19", bpm_ready, 1);
    offer(241, 1'b1, hs);
    check("ready after bpm 241", bpm_ready, 1);
    repeat (50) @(negedge clk);
    check("no beat after bad rates", beat, 0);
    check("count after bad rates", beat_count, 0);

    // 60 bpm: 34-cycle start latency, 1000-cycle period.
    offer(60, 1'b0, hs);
    check("ready low while dividing", bpm_ready, 0);
    r0 = hs + 34;
    push_beat(r0, 1);
    push_beat(r0 + 1000, 2);
    push_beat(r0 + 2000, 3);
    push_beat(r0 + 3000, 4);
    push_beat(r0 + 3500, 5);
    wait_until(r0 + 10);
    check("active while running", active, 1);

    // 120 bpm loaded mid-period: current period stays 1000, next is 500.
    wait_until(r0 + 2300);
    offer(120, 1'b0, hs);

    // en dropped mid-HIGH: pulse and period complete, then IDLE.
    wait_until(r0 + 3510);
    en = 1'b0;
    wait_until(r0 + 4200);
    check("beat low after en drop", beat, 0);
    check("inactive after en drop", active, 0);
    check("count after en drop", beat_count, 5);

    en = 1'b1;
    n  = cyc + 1;
    push_beat(n, 6);
    push_beat(n + 500, 7);
    wait_until(n + 600);
    en = 1'b0;
    wait_until(n + 1100);
    check("count after resume", beat_count, 7);
    check("beat low after resume stop", beat, 0);

    // 240 bpm -> 250 cycles; bpm 7 rejected first.
    do_reset();
    en = 1'b1;
    offer(7, 1'b1, hs);
    offer(240, 1'b0, hs);
    r0 = hs + 34;
    push_beat(r0, 1);
    push_beat(r0 + 250, 2);
    push_beat(r0 + 500, 3);
    wait_until(r0 + 600);
    en = 1'b0;
    wait_until(r0 + 800);
    check("count at 240 bpm", beat_count, 3);

    // 200 bpm -> floor(60000/200) = 300 cycles.
    do_reset();
    en = 1'b1;
    offer(200, 1'b0, hs);
    r0 = hs + 34;
    push_beat(r0, 1);
    push_beat(r0 + 300, 2);
    wait_until(r0 + 360);
    en = 1'b0;
    wait_until(r0 + 700);
    check("count at 200 bpm", beat_count, 2);

    // Reset mid-divide: nothing may beat afterwards.
    do_reset();
    en = 1'b1;
    offer(60, 1'b0, hs);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (200) @(negedge clk);
    check("count after mid-divide reset", beat_count, 0);
    check("beat after mid-divide reset", beat, 0);
    check("ready after mid-divide reset", bpm_ready, 1);

    // Reset mid-HIGH: beat drops at once, and stays off without a new load.
    offer(60, 1'b0, hs);
    push_beat(hs + 34, 1);
    wait_until(hs + 44);
    check("beat high before reset", beat, 1);
    do_reset();
    repeat (300) @(negedge clk);
    check("count after mid-beat reset", beat_count, 0);
    check("beat after mid-beat reset", beat, 0);

    check("beats outstanding at end", beat_q.size(), 0);
    check("rate_err outstanding at end", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
